// File: rtl/if_fetch_if.sv
// Instruction-memory request/ack channel between fetch and memory.
// The master issues one word request and the slave answers with a one-cycle ack strobe.
interface if_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory request, with branch
// buffering and a flush redirect that drops any in-flight reply.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    if_fetch_if.master  imem,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_q;
    logic [31:0] r_inst_q;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;

    state_t      w_nstate;
    logic [31:0] w_pc;
    logic [31:0] w_pc_q;
    logic [31:0] w_inst_q;
    logic        w_br_pend;
    logic [31:0] w_br_tgt;
    logic        w_adv;
    logic [31:0] w_pc_inc;
    logic        w_unused;

    assign w_unused = ^{stall[5:1], r_pc[1:0]};
    assign w_pc_inc = r_pc + 32'd4;
    assign w_adv    = (r_state == S_FULL) && !stall[0] && !flush;

    always_comb begin
        w_nstate  = r_state;
        w_pc      = r_pc;
        w_pc_q    = r_pc_q;
        w_inst_q  = r_inst_q;
        w_br_pend = r_br_pend;
        w_br_tgt  = r_br_tgt;
        if (flush) begin
            w_pc      = new_pc;
            w_br_pend = 1'b0;
            // A reply still owed by memory must be swallowed in DROP.
            if (r_state == S_DROP ||
                (r_state == S_REQ && !imem.inst_ack))
                w_nstate = S_DROP;
            else
                w_nstate = S_REQ;
        end else begin
            if (branch_flag_i && !w_adv) begin
                w_br_pend = 1'b1;
                w_br_tgt  = branch_target_i;
            end
            unique case (r_state)
                S_IDLE: w_nstate = S_REQ;
                S_REQ: begin
                    if (imem.inst_ack) begin
                        w_pc_q   = r_pc;
                        w_inst_q = imem.inst_rdata;
                        w_nstate = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_adv) begin
                        if (branch_flag_i)
                            w_pc = branch_target_i;
                        else if (r_br_pend)
                            w_pc = r_br_tgt;
                        else
                            w_pc = w_pc_inc;
                        w_br_pend = 1'b0;
                        w_nstate  = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.inst_ack)
                        w_nstate = S_REQ;
                end
                default: w_nstate = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_pc_q    <= 32'd0;
            r_inst_q  <= 32'd0;
            r_br_pend <= 1'b0;
            r_br_tgt  <= 32'd0;
        end else begin
            r_state   <= w_nstate;
            r_pc      <= w_pc;
            r_pc_q    <= w_pc_q;
            r_inst_q  <= w_inst_q;
            r_br_pend <= w_br_pend;
            r_br_tgt  <= w_br_tgt;
        end
    end

    assign imem.inst_req  = (r_state == S_REQ);
    assign imem.inst_addr = {r_pc[31:2], 2'b00};
    assign if_pc          = (r_state == S_FULL) ? r_pc_q : 32'd0;
    assign if_inst        = (r_state == S_FULL) ? r_inst_q : 32'd0;
    assign stallreq_if    = (r_state != S_FULL);

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch, stall, branch,
// flush, address wrap and reset-abandon scenarios.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        flush;
    logic [31:0] npc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    if_fetch_if imem ();

    if_fetch #(
        .RESET_PC(32'hBFC0_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (br),
        .branch_target_i (br_tgt),
        .flush           (flush),
        .new_pc          (npc),
        .imem            (imem.master),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_if     (stallreq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] q_addr[$];
    logic [63:0] q_out[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    logic        m_req;
    logic        m_full;
    logic        m_af;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    int          m_rlen;
    int          m_flen;
    int          last_rlen = 0;
    int          last_flen = 0;

    initial begin
        m_req  = 1'b0;
        m_full = 1'b0;
        m_af   = 1'b0;
        m_addr = 32'd0;
        m_pc   = 32'd0;
        m_inst = 32'd0;
        m_rlen = 0;
        m_flen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_req  = 1'b0;
                m_full = 1'b0;
                m_af   = 1'b0;
                m_rlen = 0;
                m_flen = 0;
            end else begin
                if (imem.inst_req) begin
                    if (!m_req || m_af) begin
                        if (q_addr.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL req_unexp: got %h want none",
                                     imem.inst_addr);
                        end else begin
                            chk("req_addr", imem.inst_addr,
                                q_addr.pop_front());
                        end
                        m_rlen = 1;
                    end else begin
                        chk("req_stable", imem.inst_addr, m_addr);
                        m_rlen++;
                    end
                    m_addr = imem.inst_addr;
                end else if (m_req) begin
                    last_rlen = m_rlen;
                end
                if (!stallreq) begin
                    if (!m_full) begin
                        if (q_out.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL out_unexp: got %h want none",
                                     if_inst);
                            m_pc   = 32'hx;
                            m_inst = 32'hx;
                        end else begin
                            {m_pc, m_inst} = q_out.pop_front();
                        end
                        m_flen = 0;
                    end
                    chk("if_pc", if_pc, m_pc);
                    chk("if_inst", if_inst, m_inst);
                    m_flen++;
                end else begin
                    if (m_full) last_flen = m_flen;
                    chk("empty_pc", if_pc, 32'd0);
                    chk("empty_inst", if_inst, 32'd0);
                end
                m_req  = imem.inst_req;
                m_full = !stallreq;
                m_af   = imem.inst_ack | flush;
            end
        end
    end

    task automatic wait_req();
        int k;
        k = 0;
        @(negedge clk);
        while (!imem.inst_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!imem.inst_req) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: got 0 want 1");
        end
        #1;
    endtask

    task automatic do_ack(input int d, input logic [31:0] data);
        repeat (d) @(posedge clk);
        @(posedge clk);
        #1;
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = data;
        @(posedge clk);
        #1;
        imem.inst_ack   = 1'b0;
        imem.inst_rdata = 32'd0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b0;
        stall           = 6'd0;
        br              = 1'b0;
        br_tgt          = 32'd0;
        flush           = 1'b0;
        npc             = 32'd0;
        imem.inst_ack   = 1'b0;
        imem.inst_rdata = 32'd0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem.inst_req}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq}, 32'd1);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        q_addr.push_back(32'hBFC0_0000);
        @(posedge clk);
        #1 rst = 1'b1;

        // first fetch, then hold FULL under stall for 3 cycles
        wait_req();
        stall = 6'h01;
        q_out.push_back({32'hBFC0_0000, 32'h2402_0001});
        q_addr.push_back(32'hBFC0_0004);
        do_ack(0, 32'h2402_0001);
        @(posedge clk);
        @(posedge clk);
        #1 stall = 6'h00;

        // slow memory: request held 4 cycles
        wait_req();
        chk("stall_hold_len", last_flen, 32'd3);
        q_out.push_back({32'hBFC0_0004, 32'h8C43_0004});
        q_addr.push_back(32'hBFC0_0008);
        do_ack(2, 32'h8C43_0004);

        // branch seen while in REQ is buffered for the next advance
        wait_req();
        chk("req_len", last_rlen, 32'd4);
        @(posedge clk);
        #1;
        br     = 1'b1;
        br_tgt = 32'hBFC0_0100;
        @(posedge clk);
        #1 br = 1'b0;
        q_out.push_back({32'hBFC0_0008, 32'h0085_1020});
        q_addr.push_back(32'hBFC0_0100);
        do_ack(0, 32'h0085_1020);

        // flush in REQ without ack: late word must be dropped
        wait_req();
        q_addr.push_back(32'hBFC0_0380);
        @(posedge clk);
        #1;
        flush = 1'b1;
        npc   = 32'hBFC0_0380;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("drop_req", {31'd0, imem.inst_req}, 32'd0);
        chk("drop_stallreq", {31'd0, stallreq}, 32'd1);
        @(posedge clk);
        #1;
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        imem.inst_ack   = 1'b0;
        imem.inst_rdata = 32'd0;

        wait_req();
        q_out.push_back({32'hBFC0_0380, 32'h3C1A_0001});
        q_addr.push_back(32'hBFC0_0384);
        do_ack(0, 32'h3C1A_0001);

        // flush with same-cycle ack: word discarded, redirect to wrap point
        wait_req();
        q_addr.push_back(32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        flush           = 1'b1;
        npc             = 32'hFFFF_FFFC;
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = 32'hBAAD_F00D;
        @(posedge clk);
        #1;
        flush           = 1'b0;
        imem.inst_ack   = 1'b0;
        imem.inst_rdata = 32'd0;

        wait_req();
        q_out.push_back({32'hFFFF_FFFC, 32'h0000_000C});
        q_addr.push_back(32'h0000_0000);
        do_ack(0, 32'h0000_000C);

        // asynchronous reset mid-request, late ack ignored in IDLE
        wait_req();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_req", {31'd0, imem.inst_req}, 32'd0);
        chk("async_stallreq", {31'd0, stallreq}, 32'd1);
        chk("async_if_pc", if_pc, 32'd0);
        q_addr.push_back(32'hBFC0_0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst             = 1'b1;
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        imem.inst_ack   = 1'b0;
        imem.inst_rdata = 32'd0;

        wait_req();
        q_out.push_back({32'hBFC0_0000, 32'h2408_0002});
        q_addr.push_back(32'hBFC0_0004);
        do_ack(0, 32'h2408_0002);

        wait_req();
        repeat (2) @(negedge clk);
        chk("addr_q_drained", q_addr.size(), 32'd0);
        chk("out_q_drained", q_out.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
